// File: rtl/csi2tx_sync_pulse_mc.sv
// csi2tx_sync_pulse_mc
// Multi-channel pulse synchronizer with per-channel event buffering.
// Each toggle-encoded input is synchronized into clk_out. Every edge gives a
// one-cycle out_pulse bit and is also counted in a saturating pending
// counter. The pending events are drained one per cycle through a
// round-robin valid/ready port.
//
// Ports:
//   clk_out    destination clock
//   rstb_n     asynchronous active-low reset
//   in_toggle  [NUM_CH] toggle-encoded events, asynchronous to clk_out
//   out_pulse  [NUM_CH] one-cycle pulse per synchronized event
//   out_valid  buffered event available
//   out_ch     [CH_W] channel of the buffered event
//   out_ready  consumer accepts when out_valid && out_ready
//   ovf        [NUM_CH] sticky overflow flag (pending counter saturated)
//   clr_ovf    [NUM_CH] overflow clear (a new overflow wins)
module csi2tx_sync_pulse_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_out,
  input  logic              rstb_n,
  input  logic [NUM_CH-1:0] in_toggle,
  output logic [NUM_CH-1:0] out_pulse,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0] edge_r;
  logic [CNT_W-1:0]  pend_r [NUM_CH];
  logic [CH_W-1:0]   rr_r;

  logic [CH_W-1:0]   sel_s;
  logic              found_s;
  logic              load_en_s;
  logic [NUM_CH-1:0] dec_s;
  logic [NUM_CH-1:0] sat_s;

  // Synchronizer chain plus the edge-detect flop per channel.
  always_ff @(posedge clk_out or negedge rstb_n) begin
    if (!rstb_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      edge_r <= '0;
    end else begin
      sync_r[0] <= in_toggle;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // XOR of two flops: glitch-free, no extra latency.
  assign out_pulse = sync_r[SYNC_STAGES-1] ^ edge_r;

  // Round-robin pick: first non-empty channel starting just after rr_r.
  always_comb begin
    logic hit;
    int unsigned idx;
    sel_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx     = (int'(rr_r) + 1 + i) % NUM_CH;
      hit     = !found_s && (pend_r[CH_W'(idx)] != '0);
      found_s = found_s | hit;
      sel_s   = hit ? CH_W'(idx) : sel_s;
    end
  end

  // Load strobe, per-channel decrement and saturation flags.
  always_comb begin
    load_en_s = (!out_valid || out_ready) && found_s;
    dec_s     = '0;
    dec_s[sel_s] = load_en_s;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sat_s[ch] = (pend_r[ch] == CNT_MAX);
    end
  end

  // Pending counters and sticky overflow flags.
  always_ff @(posedge clk_out or negedge rstb_n) begin
    if (!rstb_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pend_r[ch] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        case ({out_pulse[ch], dec_s[ch]})
          2'b10: begin
            if (!sat_s[ch]) begin
              pend_r[ch] <= pend_r[ch] + CNT_W'(1);
            end
          end
          2'b01:   pend_r[ch] <= pend_r[ch] - CNT_W'(1);
          default: pend_r[ch] <= pend_r[ch];
        endcase
        // An increment lost at saturation overrides a simultaneous clear.
        if (out_pulse[ch] && !dec_s[ch] && sat_s[ch]) begin
          ovf[ch] <= 1'b1;
        end else if (clr_ovf[ch]) begin
          ovf[ch] <= 1'b0;
        end
      end
    end
  end

  // Output register; held while the consumer stalls.
  always_ff @(posedge clk_out or negedge rstb_n) begin
    if (!rstb_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      rr_r      <= CH_W'(NUM_CH - 1);
    end else if (!out_valid || out_ready) begin
      if (found_s) begin
        out_valid <= 1'b1;
        out_ch    <= sel_s;
        rr_r      <= sel_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csi2tx_sync_pulse_mc.sv
// Self-checking bench for csi2tx_sync_pulse_mc: directed latency, round-robin,
// saturation and reset scenarios plus randomized traffic, all compared with
// an event-level reference model.
module tb_csi2tx_sync_pulse_mc;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic         clk_out = 1'b0;
  logic         rstb_n;
  logic [N-1:0] in_toggle;
  logic [N-1:0] out_pulse;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic         out_ready;
  logic [N-1:0] ovf;
  logic [N-1:0] clr_ovf;

  csi2tx_sync_pulse_mc #(.NUM_CH(N), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk_out(clk_out), .rstb_n(rstb_n), .in_toggle(in_toggle),
    .out_pulse(out_pulse), .out_valid(out_valid), .out_ch(out_ch),
    .out_ready(out_ready), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk_out = ~clk_out;

  int n_chk = 0;
  int n_fail = 0;
  int hs = 0;
  int cyc_n = 0;

  // Reference model: input history, pending counts, presented event.
  bit [N-1:0] sh [S+1];
  int         pend_m [N];
  bit [N-1:0] ovf_m;
  bit         valid_m;
  int         ch_m;
  int         rr_m;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= S; i++) sh[i] = '0;
    for (int c = 0; c < N; c++) pend_m[c] = 0;
    ovf_m = '0; valid_m = 1'b0; ch_m = 0; rr_m = N - 1;
  endtask

  // One clock: advance model across the edge, then compare 1 ns later.
  task automatic cyc();
    bit [N-1:0] pul, tog, clr;
    bit can, rdy, inc, dec, sat;
    int sel, c;
    tog = in_toggle; clr = clr_ovf; rdy = out_ready;
    if (out_valid && out_ready) hs++;
    @(posedge clk_out);
    pul = sh[S-1] ^ sh[S];
    can = !valid_m || rdy;
    sel = -1;
    if (can) begin
      for (int i = 0; i < N; i++) begin
        c = (rr_m + 1 + i) % N;
        if (sel < 0 && pend_m[c] > 0) sel = c;
      end
    end
    for (int k = 0; k < N; k++) begin
      inc = pul[k];
      dec = (sel == k);
      sat = inc && !dec && (pend_m[k] == MAX);
      if (inc && !dec) begin
        if (sat) ovf_m[k] = 1'b1;
        else pend_m[k]++;
      end else if (dec && !inc) begin
        pend_m[k]--;
      end
      if (clr[k] && !sat) ovf_m[k] = 1'b0;
    end
    if (can) begin
      if (sel >= 0) begin valid_m = 1'b1; ch_m = sel; rr_m = sel; end
      else valid_m = 1'b0;
    end
    for (int i = S; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = tog;
    cyc_n++;
    #1;
    chk("pulse", int'(out_pulse), int'(sh[S-1] ^ sh[S]));
    chk("valid", int'(out_valid), int'(valid_m));
    if (valid_m) chk("ch", int'(out_ch), ch_m);
    chk("ovf", int'(ovf), int'(ovf_m));
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic one(int c);
    in_toggle[c] = ~in_toggle[c];
    run(8);
  endtask

  // Fire ch0, ch1, ch3 together and check the drain order.
  task automatic rr_run(int e0, int e1, int e2);
    int seq[$];
    int exp_a[3];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2;
    in_toggle = in_toggle ^ 4'b1011;
    repeat (8) begin
      cyc();
      if (out_valid) seq.push_back(int'(out_ch));
    end
    chk("rr_count", seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("rr_order", (i < seq.size()) ? seq[i] : -1, exp_a[i]);
    end
  endtask

  initial begin
    int last [N];
    int thr;
    rstb_n = 1'b0; in_toggle = '0; out_ready = 1'b1; clr_ovf = '0;
    model_reset();
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_pulse", int'(out_pulse), 0);
    rstb_n = 1'b1;

    // Single event latency on ch2.
    run(3);
    in_toggle[2] = 1'b1;
    cyc(); chk("se_pulse_k", int'(out_pulse), 0);
    cyc(); chk("se_pulse_k1", int'(out_pulse), 4);
    cyc(); chk("se_pulse_k2", int'(out_pulse), 0);
    chk("se_valid_k2", int'(out_valid), 0);
    cyc(); chk("se_valid_k3", int'(out_valid), 1);
    chk("se_ch_k3", int'(out_ch), 2);
    cyc(); chk("se_valid_k4", int'(out_valid), 0);
    run(4);

    // Round robin from rr=3, then from rr=1.
    one(3);
    rr_run(0, 1, 3);
    one(1);
    rr_run(3, 0, 1);

    // Saturation on ch0 with the consumer stalled.
    out_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin
      in_toggle[0] = ~in_toggle[0];
      run(4);
    end
    chk("pre_sat_ovf", int'(ovf[0]), 0);
    in_toggle[0] = ~in_toggle[0];
    run(4);
    chk("sat_ovf", int'(ovf[0]), 1);
    chk("sat_hold_ch", int'(out_ch), 0);
    hs = 0;
    out_ready = 1'b1;
    run(8);
    chk("sat_hs", hs, 4);
    clr_ovf[0] = 1'b1; cyc(); clr_ovf[0] = 1'b0;
    chk("clr_ovf", int'(ovf[0]), 0);

    // Overflow and clear in the same cycle: overflow wins.
    out_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin
      in_toggle[0] = ~in_toggle[0];
      run(4);
    end
    in_toggle[0] = ~in_toggle[0];
    repeat (5) begin
      clr_ovf[0] = out_pulse[0];
      cyc();
    end
    clr_ovf[0] = 1'b0;
    chk("set_beats_clr", int'(ovf[0]), 1);
    out_ready = 1'b1;
    run(8);
    clr_ovf = 4'b1111; cyc(); clr_ovf = '0;

    // Reset in the middle of backpressure on ch1.
    out_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin
      in_toggle[1] = ~in_toggle[1];
      run(4);
    end
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_ch", int'(out_ch), 1);
    #2 rstb_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    model_reset();
    in_toggle = 4'b0010;
    #2 rstb_n = 1'b1;
    hs = 0;
    out_ready = 1'b1;
    run(10);
    chk("post_rst_events", hs, 1);

    // Randomized traffic with varying backpressure.
    for (int c = 0; c < N; c++) last[c] = cyc_n;
    thr = 70;
    for (int t = 0; t < 1200; t++) begin
      if (t % 50 == 0) thr = $urandom_range(0, 100);
      for (int c = 0; c < N; c++) begin
        if (cyc_n - last[c] >= 4 && $urandom_range(0, 5) == 0) begin
          in_toggle[c] = ~in_toggle[c];
          last[c] = cyc_n;
        end
        clr_ovf[c] = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 99) < thr);
      cyc();
    end
    clr_ovf = '0;
    out_ready = 1'b1;
    run(24);
    chk("drain_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
